// File: rtl/ahb2apb_apbm_swc_pkg.sv
// Shared types and constants for the AHB-to-APB bridge: APB sequencer state
// encoding, AHB HTRANS codes used by the front end, and parameter defaults.
package ahb2apb_pkg_swc;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_ACCESS   = 2'd2,
    ST_COMPLETE = 2'd3
  } apb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int SEL_LSB_DEF = 12;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/ahb2apb_apbm_swc_if.sv
// Request/response and APB bus bundle between the AHB front end, the APB
// master sequencer (master modport) and the peripherals (slave modport).
interface ahb2apb_apbm_swc_if #(
  parameter int NSLV = 4
);
  logic                 wreq;
  logic [31:0]          wbuffdata;
  logic [31:0]          wbuffaddr;
  logic                 rreq;
  logic [31:0]          rbuffaddr;
  logic                 done;
  logic [31:0]          rbuffdata;
  logic                 err;
  logic [31:0]          paddr;
  logic [31:0]          pwdata;
  logic                 pwrite;
  logic [NSLV-1:0]      psel;
  logic                 penable;
  logic [32*NSLV-1:0]   prdata;
  logic [NSLV-1:0]      pready;
  logic [NSLV-1:0]      pslverr;

  modport master (
    input  wreq, wbuffdata, wbuffaddr, rreq, rbuffaddr,
    output done, rbuffdata, err,
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    output wreq, wbuffdata, wbuffaddr, rreq, rbuffaddr,
    input  done, rbuffdata, err,
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ahb2apb_apbm_swc_dec.sv
// Slave-index to one-hot select decoder; an index beyond the populated
// slaves yields an all-zero select and raises miss_o.
module ahb2apb_dec_swc #(
  parameter int NSLV = 4
) (
  input  logic [3:0]      idx_i,
  output logic [NSLV-1:0] sel_o,
  output logic            miss_o
);

  // One-hot select and out-of-range detection
  always_comb begin
    sel_o  = '0;
    miss_o = ({1'b0, idx_i} >= 5'(NSLV));
    for (int i = 0; i < NSLV; i++) begin
      sel_o[i] = (idx_i == 4'(i));
    end
  end

endmodule

// File: rtl/ahb2apb_apbm_swc.sv
// APB master sequencer: captures write/read requests, runs SETUP/ACCESS to the
// decoded slave with a wait-state timeout, and returns a done pulse.
module ahb2apb_apbm_swc
  import ahb2apb_pkg_swc::*;
#(
  parameter int NSLV    = 4,
  parameter int SEL_LSB = SEL_LSB_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               hclk,
  input  logic               hrst,
  ahb2apb_apbm_swc_if.master bus
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  apb_state_e      state_q;
  logic [31:0]     paddr_q, pwdata_q, rbuf_q, pend_addr_q;
  logic            pwrite_q, penable_q, done_q, err_q, miss_q, pend_q;
  logic [NSLV-1:0] psel_q;
  logic [15:0]     cnt_q, cnt_d;

  logic [3:0]      cap_idx_s;
  logic [NSLV-1:0] dec_sel_s;
  logic            dec_miss_s;
  logic            rdy_s, slverr_s;
  logic [31:0]     rdata_s;

  // Address field to decode: the pending read in COMPLETE, else the incoming request
  always_comb begin
    if (state_q == ST_COMPLETE) begin
      cap_idx_s = pend_addr_q[SEL_LSB+3:SEL_LSB];
    end else if (bus.wreq) begin
      cap_idx_s = bus.wbuffaddr[SEL_LSB+3:SEL_LSB];
    end else begin
      cap_idx_s = bus.rbuffaddr[SEL_LSB+3:SEL_LSB];
    end
  end

  ahb2apb_dec_swc #(.NSLV(NSLV)) u_dec (
    .idx_i  (cap_idx_s),
    .sel_o  (dec_sel_s),
    .miss_o (dec_miss_s)
  );

  // Response mux from the selected slave, steered by the registered one-hot select
  always_comb begin
    rdy_s    = 1'b0;
    slverr_s = 1'b0;
    rdata_s  = 32'h0;
    for (int i = 0; i < NSLV; i++) begin
      rdy_s    = rdy_s    | (psel_q[i] & bus.pready[i]);
      slverr_s = slverr_s | (psel_q[i] & bus.pslverr[i]);
      rdata_s  = rdata_s  | (bus.prdata[32*i +: 32] & {32{psel_q[i]}});
    end
  end

  assign cnt_d = cnt_q + 16'd1;

  // Sequencer FSM with all outputs registered
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q     <= ST_IDLE;
      paddr_q     <= 32'h0;
      pwdata_q    <= 32'h0;
      rbuf_q      <= 32'h0;
      pend_addr_q <= 32'h0;
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      miss_q      <= 1'b0;
      pend_q      <= 1'b0;
      psel_q      <= '0;
      cnt_q       <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.wreq) begin
            paddr_q     <= bus.wbuffaddr;
            pwdata_q    <= bus.wbuffdata;
            pwrite_q    <= 1'b1;
            psel_q      <= dec_sel_s;
            miss_q      <= dec_miss_s;
            pend_q      <= bus.rreq;
            pend_addr_q <= bus.rbuffaddr;
            state_q     <= ST_SETUP;
          end else if (bus.rreq) begin
            paddr_q  <= bus.rbuffaddr;
            pwrite_q <= 1'b0;
            psel_q   <= dec_sel_s;
            miss_q   <= dec_miss_s;
            state_q  <= ST_SETUP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (miss_q) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            rbuf_q  <= 32'h0;
            state_q <= ST_COMPLETE;
          end else begin
            penable_q <= 1'b1;
            state_q   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (rdy_s) begin
            done_q    <= 1'b1;
            err_q     <= slverr_s;
            rbuf_q    <= pwrite_q ? rbuf_q : rdata_s;
            psel_q    <= '0;
            penable_q <= 1'b0;
            cnt_q     <= 16'd0;
            state_q   <= ST_COMPLETE;
          end else if (cnt_q == CNT_LAST) begin
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            rbuf_q    <= 32'h0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            cnt_q     <= 16'd0;
            state_q   <= ST_COMPLETE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_COMPLETE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          cnt_q  <= 16'd0;
          psel_q <= '0;
          // A read queued behind a simultaneous write goes straight to SETUP
          if (pend_q) begin
            paddr_q  <= pend_addr_q;
            pwrite_q <= 1'b0;
            pend_q   <= 1'b0;
            psel_q   <= dec_sel_s;
            miss_q   <= dec_miss_s;
            state_q  <= ST_SETUP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          psel_q    <= '0;
          penable_q <= 1'b0;
          done_q    <= 1'b0;
          err_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rbuffdata = rbuf_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;

endmodule

// File: tb/tb_ahb2apb_apbm_swc.sv
// Directed bench for the APB master sequencer; a monitor pops expected
// completions from a scoreboard queue on every done pulse.
module tb_ahb2apb_apbm_swc;

  logic hclk;
  logic hrst;

  ahb2apb_apbm_swc_if #(.NSLV(4)) bus ();

  ahb2apb_apbm_swc #(.NSLV(4), .SEL_LSB(12), .TIMEOUT(4)) dut (
    .hclk (hclk),
    .hrst (hrst),
    .bus  (bus)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk;
  int          n_fail;
  int          wait_n;
  logic        hang;
  logic [3:0]  err_mask;
  logic [127:0] prdata_v;
  int          acc_cnt;
  logic [31:0] model_rbuf;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Simple slave model: ready after wait_n ACCESS cycles unless hung
  always @(posedge hclk or posedge hrst) begin
    if (hrst) acc_cnt <= 0;
    else if (bus.penable && bus.pready == 4'b0) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign bus.pready  = (bus.penable && !hang && acc_cnt >= wait_n) ? bus.psel : 4'b0;
  assign bus.pslverr = err_mask & bus.psel;
  assign bus.prdata  = prdata_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic push(input logic e, input logic [31:0] rd, input logic is_read);
    exp_t x;
    if (is_read) model_rbuf = rd;
    x.err   = e;
    x.rdata = model_rbuf;
    sb_q.push_back(x);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge hclk) begin
    if (!hrst && bus.done) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        check("done_err", {31'h0, bus.err}, {31'h0, x.err});
        check("done_rbuffdata", bus.rbuffdata, x.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; wait_n = 0; hang = 1'b0; err_mask = 4'b0;
    model_rbuf = 32'h0;
    prdata_v = {32'hCAFE_F00D, 32'h1234_5678, 32'hDEAD_0001, 32'h0BAD_0000};
    bus.wreq = 1'b0; bus.rreq = 1'b0;
    bus.wbuffaddr = 32'h0; bus.wbuffdata = 32'h0; bus.rbuffaddr = 32'h0;
    hrst = 1'b1;
    repeat (3) tick();
    check("rst_psel", {28'h0, bus.psel}, 32'h0);
    check("rst_ctrl", {29'h0, bus.done, bus.penable, bus.pwrite}, 32'h0);
    check("rst_rbuf", bus.rbuffdata, 32'h0);
    hrst = 1'b0;
    tick();

    // Write, no wait states
    bus.wreq = 1'b1; bus.wbuffaddr = 32'h0000_1004; bus.wbuffdata = 32'hA5A5_0001;
    push(1'b0, 32'h0, 1'b0);
    tick(); bus.wreq = 1'b0;
    check("w_setup_psel", {28'h0, bus.psel}, 32'h2);
    check("w_setup_pen", {31'h0, bus.penable}, 32'h0);
    tick();
    check("w_acc_pen", {31'h0, bus.penable}, 32'h1);
    check("w_acc_pwrite", {31'h0, bus.pwrite}, 32'h1);
    check("w_acc_pwdata", bus.pwdata, 32'hA5A5_0001);
    check("w_acc_paddr", bus.paddr, 32'h0000_1004);
    tick();
    check("w_done_t3", {31'h0, bus.done}, 32'h1);
    check("w_done_psel", {28'h0, bus.psel}, 32'h0);
    tick();

    // Read, 3 wait states
    wait_n = 3;
    bus.rreq = 1'b1; bus.rbuffaddr = 32'h0000_2008;
    push(1'b0, 32'h1234_5678, 1'b1);
    tick(); bus.rreq = 1'b0;
    check("r_setup_psel", {28'h0, bus.psel}, 32'h4);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r_acc_pen", {31'h0, bus.penable}, 32'h1);
      check("r_acc_nodone", {31'h0, bus.done}, 32'h0);
    end
    tick();
    check("r_done_t6", {31'h0, bus.done}, 32'h1);
    tick();
    wait_n = 0;

    // Simultaneous write and read: write first, read follows
    bus.wreq = 1'b1; bus.wbuffaddr = 32'h0; bus.wbuffdata = 32'h5555_AAAA;
    bus.rreq = 1'b1; bus.rbuffaddr = 32'h0000_3000;
    push(1'b0, 32'h0, 1'b0);
    push(1'b0, 32'hCAFE_F00D, 1'b1);
    tick(); bus.wreq = 1'b0; bus.rreq = 1'b0;
    check("wr_setup_psel0", {28'h0, bus.psel}, 32'h1);
    tick(); tick();
    check("wr_done1", {31'h0, bus.done}, 32'h1);
    tick();
    check("wr_setup_psel3", {28'h0, bus.psel}, 32'h8);
    check("wr_rd_pwrite", {31'h0, bus.pwrite}, 32'h0);
    check("wr_rd_paddr", bus.paddr, 32'h0000_3000);
    tick(); tick();
    check("wr_done2", {31'h0, bus.done}, 32'h1);
    tick();

    // Slave error on slave 0 (write keeps rbuffdata)
    err_mask = 4'b0001;
    bus.wreq = 1'b1; bus.wbuffaddr = 32'h0000_0010; bus.wbuffdata = 32'h1;
    push(1'b1, 32'h0, 1'b0);
    tick(); bus.wreq = 1'b0;
    tick(); tick();
    check("se_done", {31'h0, bus.done}, 32'h1);
    tick();
    err_mask = 4'b0;

    // Decode miss
    bus.rreq = 1'b1; bus.rbuffaddr = 32'h0000_7000;
    push(1'b1, 32'h0, 1'b1);
    tick(); bus.rreq = 1'b0;
    check("miss_setup_psel", {28'h0, bus.psel}, 32'h0);
    tick();
    check("miss_done_t2", {31'h0, bus.done}, 32'h1);
    check("miss_done_psel", {28'h0, bus.psel}, 32'h0);
    tick();

    // Timeout: penable high for exactly 4 cycles
    hang = 1'b1;
    bus.rreq = 1'b1; bus.rbuffaddr = 32'h0000_1000;
    push(1'b1, 32'h0, 1'b1);
    tick(); bus.rreq = 1'b0;
    begin
      int pen_cnt;
      pen_cnt = 0;
      for (int i = 0; i < 8 && !bus.done; i++) begin
        tick();
        if (bus.penable) pen_cnt++;
      end
      check("to_pen_cycles", 32'(pen_cnt), 32'd4);
      check("to_done", {31'h0, bus.done}, 32'h1);
    end
    tick();

    // Reset mid-ACCESS
    bus.rreq = 1'b1; bus.rbuffaddr = 32'h0000_2000;
    tick(); bus.rreq = 1'b0;
    tick();
    check("rm_pen_before", {31'h0, bus.penable}, 32'h1);
    #2 hrst = 1'b1;
    #1;
    check("rm_psel", {28'h0, bus.psel}, 32'h0);
    check("rm_pen", {31'h0, bus.penable}, 32'h0);
    check("rm_done", {31'h0, bus.done}, 32'h0);
    tick(); tick();
    hrst = 1'b0;
    hang = 1'b0;
    model_rbuf = 32'h0;
    repeat (4) tick();
    bus.wreq = 1'b1; bus.wbuffaddr = 32'h0000_1008; bus.wbuffdata = 32'h0F0F_0F0F;
    push(1'b0, 32'h0, 1'b0);
    tick(); bus.wreq = 1'b0;
    check("post_rst_psel", {28'h0, bus.psel}, 32'h2);
    tick(); tick();
    check("post_rst_done", {31'h0, bus.done}, 32'h1);
    repeat (3) tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
